// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR output path.
package fir_pkg;

  localparam int unsigned SAMPLE_W    = 12;
  localparam int unsigned FIR_LATENCY = 33;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic {
    FILL,
    RUN
  } dec_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO with a registered head sample (no fall-through) and an occupancy count.
module sample_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 12
) (
  input  logic                     i_clk,
  input  logic                     i_clr,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_empty,
  output logic                     o_full,
  output logic                     o_drop,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic [WIDTH-1:0] r_head;

  logic             w_full;
  logic             w_empty;
  logic             w_wr;
  logic             w_rd;
  logic [PTR_W-1:0] w_rd_nxt;
  logic [LVL_W-1:0] w_level_d;
  logic [WIDTH-1:0] w_head_d;

  always_comb begin
    w_full    = (r_level == LVL_W'(DEPTH));
    w_empty   = (r_level == '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    w_wr      = i_push && (!w_full || i_pop);
    w_rd      = i_pop && !w_empty;
    w_rd_nxt  = r_rd_ptr + 1'b1;
    w_level_d = r_level;
    case ({w_wr, w_rd})
      2'b10:   w_level_d = r_level + 1'b1;
      2'b01:   w_level_d = r_level - 1'b1;
      default: w_level_d = r_level;
    endcase
    // Head register tracks mem[rd_ptr]; it holds its last value once empty.
    w_head_d = r_head;
    if (w_rd) begin
      if (r_level > LVL_W'(1)) begin
        w_head_d = r_mem[w_rd_nxt];
      end else if (w_wr) begin
        w_head_d = i_data;
      end
    end else if (w_wr && w_empty) begin
      w_head_d = i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_head   <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= w_rd_nxt;
      r_level <= w_level_d;
      r_head  <= w_head_d;
    end
  end

  assign o_data  = r_head;
  assign o_empty = w_empty;
  assign o_full  = w_full;
  assign o_drop  = i_push && w_full && !i_pop;
  assign o_level = r_level;

endmodule

// File: rtl/fir_decimator.sv
// Drops FIR pipeline-fill samples after Hlt, keeps every DEC_FACTOR-th sample,
// and buffers the kept samples for a valid/ready sink.
module fir_decimator
  import fir_pkg::*;
#(
  parameter int unsigned DEC_FACTOR  = 4,
  parameter int unsigned FILL_CYCLES = fir_pkg::FIR_LATENCY,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned SAMPLE_W    = fir_pkg::SAMPLE_W
) (
  input  logic                          Clk,
  input  logic                          Hlt,
  input  logic [SAMPLE_W-1:0]           Din,
  output logic [SAMPLE_W-1:0]           Dout,
  output logic                          DoutValid,
  input  logic                          DoutReady,
  output logic [$clog2(FIFO_DEPTH):0]   Level,
  output logic                          Overflow,
  output logic                          Running
);

  localparam int unsigned FILL_W = (FILL_CYCLES > 1) ? $clog2(FILL_CYCLES) : 1;
  localparam int unsigned PH_W   = (DEC_FACTOR > 1) ? $clog2(DEC_FACTOR) : 1;

  dec_state_t  r_state;
  dec_state_t  w_state_d;
  logic [FILL_W-1:0] r_fill_cnt;
  logic [FILL_W-1:0] w_fill_cnt_d;
  logic [PH_W-1:0]   r_phase;
  logic [PH_W-1:0]   w_phase_d;
  logic              r_overflow;

  logic w_push;
  logic w_pop;
  logic w_empty;
  logic w_full;
  logic w_drop;

  always_comb begin
    w_state_d    = r_state;
    w_fill_cnt_d = r_fill_cnt;
    w_phase_d    = r_phase;
    w_push       = 1'b0;
    case (r_state)
      FILL: begin
        w_phase_d = '0;
        if ((FILL_CYCLES <= 1) || (r_fill_cnt == FILL_W'(FILL_CYCLES - 1))) begin
          w_state_d = RUN;
        end else begin
          w_fill_cnt_d = r_fill_cnt + 1'b1;
        end
      end
      RUN: begin
        w_push    = (r_phase == '0);
        w_phase_d = (r_phase == PH_W'(DEC_FACTOR - 1)) ? '0 : r_phase + 1'b1;
      end
      default: w_state_d = FILL;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Hlt) begin
      r_state    <= FILL;
      r_fill_cnt <= '0;
      r_phase    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_fill_cnt <= w_fill_cnt_d;
      r_phase    <= w_phase_d;
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign w_pop = !w_empty && DoutReady;

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_fifo (
    .i_clk   (Clk),
    .i_clr   (Hlt),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (Din),
    .o_data  (Dout),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_drop  (w_drop),
    .o_level (Level)
  );

  assign DoutValid = !w_empty;
  assign Overflow  = r_overflow;
  assign Running   = (r_state == RUN);

endmodule

// File: doc/fir_decimator.md
Name: fir_decimator

Overview:
- Downstream stage of the 32-tap transposed FIR. Consumes the FIR's free-running 12-bit output, one sample per Clk.
- Discards the FIR pipeline-fill samples after Hlt, then keeps every DEC_FACTOR-th sample.
- Buffers kept samples in a small FIFO and presents them on a valid/ready interface to the sink (DAC/UART framer).

Parameters:
- DEC_FACTOR, 4, decimation ratio; keep 1 of every DEC_FACTOR samples; legal range 1..16
- FILL_CYCLES, 33, samples discarded after Hlt deasserts (FIR input register + 32 sum stages)
- FIFO_DEPTH, 8, output buffer entries; power of 2, 2..32
- SAMPLE_W, 12, sample width (two's complement)

Ports:
- Clk  in  1  clock; all logic rising-edge
- Hlt  in  1  reset; synchronous, active-high; single clock domain
- Din  in  SAMPLE_W  FIR output sample; one valid sample every Clk
- Dout  out  SAMPLE_W  FIFO head sample
- DoutValid  out  1  FIFO non-empty
- DoutReady  in  1  sink accepts Dout this cycle
- Level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- Overflow  out  1  sticky; a kept sample was dropped because the FIFO was full
- Running  out  1  high in RUN state

Behaviour:
- Reset (Hlt=1 at a rising edge), next cycle:
  - state=FILL, fill counter=0, phase=0, FIFO emptied.
  - Dout=0, DoutValid=0, Level=0, Overflow=0, Running=0.
  - Hlt asserted mid-operation discards all buffered data the same way; there is no partial drain.
- FILL state:
  - Counts Din samples, starting with the first cycle Hlt=0.
  - After FILL_CYCLES samples (counter reaches FILL_CYCLES-1), moves to RUN on the next edge; Running=1 from that cycle.
  - No push occurs in FILL.
  - FILL_CYCLES=0 enters RUN directly one cycle after Hlt deasserts.
- RUN state:
  - Phase counter runs 0..DEC_FACTOR-1 and wraps; it resets to 0 on entry to RUN.
  - Kept sample = Din on a cycle with phase==0. The first sample kept is the first Din seen in RUN.
  - Remains in RUN until Hlt.
- Push and pop:
  - Push request = RUN && phase==0.
  - Pop = DoutValid && DoutReady.
  - Push is accepted if Level<FIFO_DEPTH, or if Level==FIFO_DEPTH and a pop occurs the same cycle (full + simultaneous pop/push is legal; Level unchanged).
  - Push rejected when full with no pop: sample dropped, Overflow set next cycle and held until Hlt, FIFO contents unchanged.
  - Empty with push (no pop possible): Level 0->1, DoutValid=1 next cycle.
  - Push-to-DoutValid latency is 1 cycle; Dout is registered, no fall-through.
  - Pop when empty is impossible because DoutValid=0. DoutReady is ignored while DoutValid=0.
  - Dout holds its value while DoutValid && !DoutReady. Dout after the FIFO empties: last popped value (don't care, but stable).
  - Level updates every cycle: +1 on push only, -1 on pop only, 0 change on both or neither.
- Arithmetic:
  - No sample modification; Din stored bit-exact.
  - Pointers wrap modulo FIFO_DEPTH.
  - Full/empty determined from a (log2+1)-bit occupancy count.
- DEC_FACTOR=1: every RUN-cycle sample is kept. The sink must sustain DoutReady=1 or Overflow will set.

Decomposition:
- Shared package fir_pkg:
  - SAMPLE_W=12
  - FIR_LATENCY=33 (default for FILL_CYCLES)
  - sample_t = logic signed [SAMPLE_W-1:0]
  - state enum dec_state_t {FILL, RUN}
- Sub-module sample_fifo (synchronous FIFO: push/pop/full/empty/level, Hlt-cleared, registered read data), instantiated once.
- FILL/RUN control, fill counter, phase counter and Overflow stay in fir_decimator.

Test Plan:
- Reset/fill: Hlt 1 for 3 cycles then 0, Din=cycle index (0,1,2,...), DoutReady=1, defaults.
  - Running rises after the 33rd sample.
  - The first Dout with DoutValid=1 is 33, followed by 37, 41, 45.
- Backpressure: DoutReady=0 in RUN, Din ramp, DEC_FACTOR=4.
  - Level climbs 1..8 every 4 cycles.
  - The 9th kept sample is dropped and Overflow=1.
  - Releasing DoutReady drains exactly 8 values in order; the dropped value never appears.
- Full + simultaneous pop/push: FIFO at Level=8, DoutReady pulsed for 1 cycle aligned with phase==0.
  - Level stays 8, Overflow stays 0.
  - The new sample appears at the tail (8 pops later).
- Signed data: Din alternating 12'h800 / 12'h7FF with DEC_FACTOR=1.
  - Dout reproduces 12'h800, 12'h7FF, ... bit-exact; no sign extension artefacts.
- Reset mid-operation: with Level=5 and Overflow=1, assert Hlt for 1 cycle.
  - Next cycle: Level=0, DoutValid=0, Overflow=0, Running=0.
  - The FILL count restarts; the first kept sample arrives 33 cycles after Hlt deasserts.
- DEC_FACTOR=1, FILL_CYCLES=0 build: DoutReady=1, Din ramp.
  - Running=1 one cycle after Hlt drops.
  - Every sample passes with 1-cycle latency; Level stays at most 1.
